// File: rtl/vector_sequencer_if.sv
// Stimulus/handshake bundle between vector_sequencer and its driver.
// rand_mode exists only when VECSEQ_LFSR_EN is defined.
interface vector_sequencer_if #(
  parameter int WIDTH  = 2,
  parameter int ADDR_W = 4
) ();
  logic              wr_en;
  logic [ADDR_W-1:0] wr_addr;
  logic [WIDTH-1:0]  wr_data;
  logic [ADDR_W:0]   length;
  logic              loop_en;
  logic              start;
  logic              abort;
  logic              vec_ready;
`ifdef VECSEQ_LFSR_EN
  logic              rand_mode;
`endif
  logic [WIDTH-1:0]  vec_out;
  logic              vec_valid;
  logic [ADDR_W-1:0] vec_index;
  logic              busy;
  logic              done;
  logic [15:0]       pass_count;

  modport master (
    output wr_en, wr_addr, wr_data, length, loop_en, start, abort, vec_ready,
`ifdef VECSEQ_LFSR_EN
    output rand_mode,
`endif
    input  vec_out, vec_valid, vec_index, busy, done, pass_count
  );

  modport slave (
    input  wr_en, wr_addr, wr_data, length, loop_en, start, abort, vec_ready,
`ifdef VECSEQ_LFSR_EN
    input  rand_mode,
`endif
    output vec_out, vec_valid, vec_index, busy, done, pass_count
  );
endinterface

// File: rtl/vector_sequencer.sv
// Table-driven test-vector source with valid/ready playback and optional looping.
// Define VECSEQ_LFSR_EN to add an 8-bit LFSR vector source selected by rand_mode.
//   state | meaning
//   IDLE  | waiting for start; table writable
//   RUN   | streaming vectors, vec_valid high
//   DONE  | pass finished; table writable, waiting for start/abort
module vector_sequencer #(
  parameter int WIDTH  = 2,
  parameter int DEPTH  = 16,
  parameter int ADDR_W = 4
) (
  input  logic              t_clock,
  input  logic              t_reset_n,
  vector_sequencer_if.slave bus
);
  typedef enum logic [1:0] {IDLE = 2'd0, RUN = 2'd1, DONE = 2'd2} state_t;

  localparam logic [ADDR_W:0] DEPTH_L = (ADDR_W+1)'(DEPTH);

  state_t            r_state, w_state_nx;
  logic [WIDTH-1:0]  r_mem [DEPTH];
  logic [WIDTH-1:0]  r_vec, w_vec_nx, w_vec_first, w_vec_step;
  logic [ADDR_W-1:0] r_index, w_index_nx, w_index_inc;
  logic [ADDR_W:0]   r_len, w_len_nx, w_len_eff;
  logic              r_loop, w_loop_nx;
  logic [15:0]       r_pass, w_pass_nx;
  logic              w_xfer, w_last;

  assign w_len_eff   = (bus.length > DEPTH_L) ? DEPTH_L : bus.length;
  assign w_index_inc = r_index + ADDR_W'(1);
  assign w_xfer      = (r_state == RUN) && bus.vec_ready;
  assign w_last      = ({1'b0, r_index} == (r_len - (ADDR_W+1)'(1)));

`ifdef VECSEQ_LFSR_EN
  localparam logic [7:0] SEED = 8'hA5;
  logic [7:0] r_lfsr, w_lfsr_nx, w_lfsr_step;
  logic       r_rand, w_rand_nx;

  // Fibonacci taps for x^8+x^6+x^5+x^4+1
  assign w_lfsr_step = {r_lfsr[6:0], r_lfsr[7] ^ r_lfsr[5] ^ r_lfsr[4] ^ r_lfsr[3]};
  assign w_vec_first = bus.rand_mode ? SEED[WIDTH-1:0] : r_mem[0];
  assign w_vec_step  = r_rand ? w_lfsr_step[WIDTH-1:0]
                              : (w_last ? r_mem[0] : r_mem[w_index_inc]);
`else
  assign w_vec_first = r_mem[0];
  assign w_vec_step  = w_last ? r_mem[0] : r_mem[w_index_inc];
`endif

  always_comb begin
    w_state_nx = r_state;
    w_vec_nx   = r_vec;
    w_index_nx = r_index;
    w_len_nx   = r_len;
    w_loop_nx  = r_loop;
    w_pass_nx  = r_pass;
`ifdef VECSEQ_LFSR_EN
    w_lfsr_nx  = r_lfsr;
    w_rand_nx  = r_rand;
`endif
    if (bus.abort) begin
      w_state_nx = IDLE;
    end else begin
      case (r_state)
        IDLE, DONE: begin
          if (bus.start) begin
            w_len_nx   = w_len_eff;
            w_loop_nx  = bus.loop_en;
            w_pass_nx  = '0;
            w_index_nx = '0;
`ifdef VECSEQ_LFSR_EN
            w_rand_nx  = bus.rand_mode;
            w_lfsr_nx  = SEED;
`endif
            if (w_len_eff == '0) begin
              w_state_nx = DONE;
            end else begin
              w_state_nx = RUN;
              w_vec_nx   = w_vec_first;
            end
          end
        end
        RUN: begin
          if (w_xfer) begin
`ifdef VECSEQ_LFSR_EN
            w_lfsr_nx = w_lfsr_step;
`endif
            if (w_last) begin
              if (r_pass != 16'hFFFF) w_pass_nx = r_pass + 16'd1;
              if (r_loop) begin
                w_index_nx = '0;
                w_vec_nx   = w_vec_step;
              end else begin
                w_state_nx = DONE;
              end
            end else begin
              w_index_nx = w_index_inc;
              w_vec_nx   = w_vec_step;
            end
          end
        end
        default: w_state_nx = IDLE;
      endcase
    end
  end

  always_ff @(posedge t_clock) begin
    if (!t_reset_n) begin
      r_state <= IDLE;
      r_vec   <= '0;
      r_index <= '0;
      r_len   <= '0;
      r_loop  <= 1'b0;
      r_pass  <= '0;
`ifdef VECSEQ_LFSR_EN
      r_lfsr  <= SEED;
      r_rand  <= 1'b0;
`endif
    end else begin
      r_state <= w_state_nx;
      r_vec   <= w_vec_nx;
      r_index <= w_index_nx;
      r_len   <= w_len_nx;
      r_loop  <= w_loop_nx;
      r_pass  <= w_pass_nx;
`ifdef VECSEQ_LFSR_EN
      r_lfsr  <= w_lfsr_nx;
      r_rand  <= w_rand_nx;
`endif
    end
  end

  // Table survives reset; frozen while streaming so a pass sees a stable table.
  always_ff @(posedge t_clock) begin
    if (bus.wr_en && (r_state != RUN)) r_mem[bus.wr_addr] <= bus.wr_data;
  end

  assign bus.vec_out    = r_vec;
  assign bus.vec_valid  = (r_state == RUN);
  assign bus.vec_index  = r_index;
  assign bus.busy       = (r_state == RUN);
  assign bus.done       = (r_state == DONE);
  assign bus.pass_count = r_pass;
endmodule

// File: tb/tb_vector_sequencer.sv
// Directed self-checking bench for vector_sequencer; inputs change and outputs
// are sampled on the falling clock edge.
module tb_vector_sequencer;
  localparam int WIDTH  = 2;
  localparam int DEPTH  = 16;
  localparam int ADDR_W = 4;

  logic t_clock = 1'b0;
  logic t_reset_n;
  int   checks = 0;
  int   errors = 0;

  always #5 t_clock = ~t_clock;

  vector_sequencer_if #(.WIDTH(WIDTH), .ADDR_W(ADDR_W)) bus ();

  vector_sequencer #(.WIDTH(WIDTH), .DEPTH(DEPTH), .ADDR_W(ADDR_W)) dut (
    .t_clock  (t_clock),
    .t_reset_n(t_reset_n),
    .bus      (bus)
  );

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(negedge t_clock);
  endtask

  task automatic start_run(input int len, input logic lp);
    bus.length  = len[ADDR_W:0];
    bus.loop_en = lp;
    bus.start   = 1'b1;
    tick();
    bus.start   = 1'b0;
  endtask

  initial begin
    t_reset_n     = 1'b0;
    bus.wr_en     = 1'b0;
    bus.wr_addr   = '0;
    bus.wr_data   = '0;
    bus.length    = '0;
    bus.loop_en   = 1'b0;
    bus.start     = 1'b0;
    bus.abort     = 1'b0;
    bus.vec_ready = 1'b0;
`ifdef VECSEQ_LFSR_EN
    bus.rand_mode = 1'b0;
`endif

    // reset held for 3 clocks
    repeat (3) tick();
    t_reset_n = 1'b1;
    chk("rst_vec_out", bus.vec_out, 0);
    chk("rst_valid", bus.vec_valid, 0);
    chk("rst_index", bus.vec_index, 0);
    chk("rst_busy", bus.busy, 0);
    chk("rst_done", bus.done, 0);
    chk("rst_pass", bus.pass_count, 0);

    // table: mem[i] = i mod 4
    for (int i = 0; i < DEPTH; i++) begin
      bus.wr_en   = 1'b1;
      bus.wr_addr = i[ADDR_W-1:0];
      bus.wr_data = i[WIDTH-1:0];
      tick();
    end
    bus.wr_en = 1'b0;

    // basic pass
    bus.vec_ready = 1'b1;
    start_run(4, 1'b0);
    chk("basic_busy", bus.busy, 1);
    for (int k = 0; k < 4; k++) begin
      chk("basic_vec", bus.vec_out, k);
      chk("basic_idx", bus.vec_index, k);
      chk("basic_valid", bus.vec_valid, 1);
      tick();
    end
    chk("basic_done", bus.done, 1);
    chk("basic_valid_end", bus.vec_valid, 0);
    chk("basic_pass", bus.pass_count, 1);
    chk("basic_busy_end", bus.busy, 0);

    // backpressure
    bus.vec_ready = 1'b0;
    start_run(4, 1'b0);
    chk("bp_pass_clr", bus.pass_count, 0);
    for (int k = 0; k < 5; k++) begin
      chk("bp_hold_vec", bus.vec_out, 0);
      chk("bp_hold_idx", bus.vec_index, 0);
      chk("bp_hold_valid", bus.vec_valid, 1);
      tick();
    end
    bus.vec_ready = 1'b1;
    for (int k = 0; k < 4; k++) begin
      chk("bp_vec", bus.vec_out, k);
      chk("bp_idx", bus.vec_index, k);
      tick();
    end
    chk("bp_done", bus.done, 1);
    chk("bp_pass", bus.pass_count, 1);

    // loop and wrap
    start_run(2, 1'b1);
    for (int k = 0; k < 8; k++) begin
      chk("loop_vec", bus.vec_out, k % 2);
      chk("loop_busy", bus.busy, 1);
      tick();
    end
    chk("loop_pass", bus.pass_count, 4);
    chk("loop_valid", bus.vec_valid, 1);
    bus.abort = 1'b1;
    tick();
    bus.abort = 1'b0;
    chk("abort_valid", bus.vec_valid, 0);
    chk("abort_busy", bus.busy, 0);
    chk("abort_done", bus.done, 0);
    chk("abort_pass_hold", bus.pass_count, 4);

    // zero length
    start_run(0, 1'b0);
    chk("len0_done", bus.done, 1);
    chk("len0_valid", bus.vec_valid, 0);
    chk("len0_pass", bus.pass_count, 0);
    tick();
    chk("len0_valid2", bus.vec_valid, 0);
    chk("len0_done2", bus.done, 1);

    // length 20 clamps to 16; write during RUN must be ignored
    start_run(20, 1'b0);
    for (int k = 0; k < 16; k++) begin
      if (k == 2) begin
        bus.wr_en   = 1'b1;
        bus.wr_addr = 4'd10;
        bus.wr_data = 2'd3;
      end else begin
        bus.wr_en = 1'b0;
      end
      chk("len20_idx", bus.vec_index, k);
      chk("len20_vec", bus.vec_out, k % 4);
      tick();
    end
    bus.wr_en = 1'b0;
    chk("len20_done", bus.done, 1);
    chk("len20_pass", bus.pass_count, 1);
    chk("len20_valid", bus.vec_valid, 0);

    // abort and start together at index 2
    start_run(4, 1'b0);
    tick();
    tick();
    chk("abst_idx", bus.vec_index, 2);
    bus.abort = 1'b1;
    bus.start = 1'b1;
    tick();
    bus.abort = 1'b0;
    bus.start = 1'b0;
    chk("abst_valid", bus.vec_valid, 0);
    chk("abst_busy", bus.busy, 0);
    chk("abst_done", bus.done, 0);
    tick();
    chk("abst_busy2", bus.busy, 0);

    // reset mid-run at index 1 with a nonzero pass count
    start_run(2, 1'b1);
    tick();
    tick();
    tick();
    chk("mrst_pre_idx", bus.vec_index, 1);
    chk("mrst_pre_vec", bus.vec_out, 1);
    chk("mrst_pre_pass", bus.pass_count, 1);
    t_reset_n = 1'b0;
    tick();
    chk("mrst_vec", bus.vec_out, 0);
    chk("mrst_valid", bus.vec_valid, 0);
    chk("mrst_idx", bus.vec_index, 0);
    chk("mrst_busy", bus.busy, 0);
    chk("mrst_done", bus.done, 0);
    chk("mrst_pass", bus.pass_count, 0);
    t_reset_n = 1'b1;
    tick();

    // table survived reset; a write is visible to a start on the next cycle
    bus.wr_en   = 1'b1;
    bus.wr_addr = 4'd0;
    bus.wr_data = 2'd3;
    tick();
    bus.wr_en = 1'b0;
    start_run(1, 1'b0);
    chk("wvis_vec", bus.vec_out, 3);
    tick();
    chk("wvis_done", bus.done, 1);
    chk("wvis_pass", bus.pass_count, 1);
    start_run(4, 1'b0);
    tick();
    chk("keep_tbl_vec", bus.vec_out, 1);
    tick();
    tick();
    tick();

`ifdef VECSEQ_LFSR_EN
    // LFSR seeded A5: low bits 1, then 4A -> 2, then 95 -> 1
    bus.rand_mode = 1'b1;
    start_run(3, 1'b0);
    bus.rand_mode = 1'b0;
    chk("lfsr_v0", bus.vec_out, 1);
    tick();
    chk("lfsr_v1", bus.vec_out, 2);
    tick();
    chk("lfsr_v2", bus.vec_out, 1);
    tick();
    chk("lfsr_done", bus.done, 1);
`endif

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
